mnist_infer_sequencer: RTL
==========================

# mnist_infer_sequencer

Top-level sequencer for the two-layer MNIST MLP datapath: test-image ROM, bias ROMs, layer-1/layer-2 weight ROMs, 10+10 accumulating neurons. On a `start` pulse it clears the neurons and loads layer-1 biases. It then streams 784 pixel addresses, loads layer-2 biases and streams 10 hidden-neuron addresses. Finally it runs a sequential signed argmax over the 10 digit scores and drives the classified digit to LEDs with a start/busy/done handshake.

## Interface
- `N_PIX`, 784, pixels per image; pixel-address range is 0..N_PIX-1.
- `N_HID`, 10, layer-1 neurons (≤10).
- `N_OUT`, 10, layer-2 neurons (≤10).
- `ROM_LAT`, 1, ROM read latency in cycles (≥1); all data strobes lag their address by this amount.

- `clk`  in  1  system clock (MAX10_CLK1_50).
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin inference; sampled only in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse; `digit` is valid.
- `neuron_clr`  out  1  one-cycle accumulator clear to all neurons.
- `pixel_addr`  out  12  test-image and layer-1 weight ROM address.
- `bias_addr`  out  4  bias ROM address (bias_mem1 in BIAS1, bias_mem2 in BIAS2).
- `bias_load_l1`  out  12  one-hot; bit k+1 loads layer-1 neuron k; bits 0 and 11 are always 0.
- `bias_load_l2`  out  12  the same encoding for layer-2 neurons.
- `valid_l1`  out  1  layer-1 accumulate strobe.
- `hid_addr`  out  4  relu mux select and layer-2 weight ROM address.
- `valid_l2`  out  1  layer-2 accumulate strobe.
- `score_sel`  out  4  digit_output mux select for argmax.
- `score`  in  32  signed score of `digit_output[score_sel]`; combinational, same cycle.
- `digit`  out  4  classified digit.
- `digit_onehot`  out  10  LEDR drive; bit `digit` is set.

## Operation
- States:
  - IDLE → CLR (1 cycle) → BIAS1 (N_HID) → PIX (N_PIX) → DRAIN1 (ROM_LAT) → BIAS2 (N_OUT) → HID (N_HID) → DRAIN2 (ROM_LAT) → SETTLE (1) → ARG (N_OUT) → DONE (1) → IDLE.
- A single phase counter is reloaded at every state entry. Addresses equal the counter value during their issue state and hold 0 otherwise.
- Address-phase strobes pass through a ROM_LAT-deep shift register to become `bias_load_l1/l2`, `valid_l1` and `valid_l2`. As a result, strobe and ROM data always coincide.
  - The BIAS1 issue at count k yields `bias_load_l1` = 1<<(k+1), ROM_LAT cycles later.
  - The strobes from different phases never overlap in the same cycle.
- ARG:
  - `score_sel` = count.
  - At count 0, `best` ← score and `idx` ← 0.
  - Afterwards, update only when score > best (signed, strict), so ties resolve to the lowest index.
- DONE: `digit` ← idx and `digit_onehot` ← 1<<idx. `done` = 1. Both outputs hold until the next DONE or reset.
- `start` while busy is ignored.
- `abort`:
  - Returns to IDLE on the next edge and clears the shift register and all strobes.
  - Asserts no `done`.
  - `digit` and `digit_onehot` keep their previous values.
  - `abort` has priority over `start` in the same cycle.
- `rst_n` low, at any time: every output becomes 0 immediately and the state becomes IDLE.

## Timing
- Count cycles from the IDLE cycle where `start` = 1, which is cycle 0.
- With the defaults:
  - CLR: cycle 1.
  - BIAS1 issue: 2–11; `bias_load_l1` active: 3–12.
  - PIX issue: 12–795; `valid_l1` active: 13–796.
  - BIAS2 issue: 797–806; `bias_load_l2` active: 798–807.
  - HID issue: 807–816; `valid_l2` active: 808–817.
  - SETTLE: 818.
  - ARG: 819–828.
  - `done` and the new `digit`: cycle 829.
- General latency: N_PIX + 2·N_HID + 2·N_OUT + 2·ROM_LAT + 3.
- `busy` is high in cycles 1–829 and low in 830. A new `start` is accepted in cycle 830 at the earliest.
- All outputs are registered. There are no combinational paths from `score` to any output.

## Test plan
- Set `score` = 100 for sel 7 and −5 otherwise; pulse `start` → `done` at cycle 829, `digit` = 7, `digit_onehot` = 10'h080, `busy` low at cycle 830.
- Address/strobe check:
  - `pixel_addr` runs 0..783 contiguously.
  - `valid_l1` is high for exactly 784 cycles (13–796).
  - `bias_load_l1` walks bits 1..10 over 3–12.
  - `bias_load_l2` walks bits 1..10 over 798–807.
  - `valid_l2` is high over 808–817 with `hid_addr` 0..9 one cycle earlier.
  - No two strobes are high in the same cycle.
- Argmax edge cases:
  - All scores −3 → `digit` = 0.
  - Score 50 at sel 2 and 5, others 0 → `digit` = 2.
  - Score 32'h7FFFFFFF at sel 9, 32'h80000000 elsewhere → `digit` = 9.
- Control edge cases:
  - Pulsing `start` at cycle 300 has no effect.
  - `abort` at cycle 400 → `busy` = 0 at 401, no `done`, `digit` stays 7.
  - A fresh `start` afterwards completes in exactly 829 cycles.
- Reset: assert `rst_n` low at cycle 500 between edges → all outputs 0 without a clock edge. After release, state is IDLE and `start` gives the full 829-cycle run.
- ROM_LAT = 2: `valid_l1` spans 14–797 and `done` arrives at cycle 831.

Source files
------------

// File: rtl/mnist_infer_sequencer.sv
// Phase sequencer for the two-layer MNIST MLP: walks bias/pixel/hidden ROM addresses,
// delays accumulate strobes to line up with ROM data, then runs a signed argmax.
module mnist_infer_sequencer #(
    parameter int N_PIX   = 784,
    parameter int N_HID   = 10,
    parameter int N_OUT   = 10,
    parameter int ROM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        neuron_clr,
    output logic [11:0] pixel_addr,
    output logic [3:0]  bias_addr,
    output logic [11:0] bias_load_l1,
    output logic [11:0] bias_load_l2,
    output logic        valid_l1,
    output logic [3:0]  hid_addr,
    output logic        valid_l2,
    output logic [3:0]  score_sel,
    input  logic [31:0] score,
    output logic [3:0]  digit,
    output logic [9:0]  digit_onehot
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_BIAS1, S_PIX, S_DRAIN1, S_BIAS2,
        S_HID, S_DRAIN2, S_SETTLE, S_ARG, S_DONE
    } state_t;

    typedef struct packed {
        logic [11:0] bl1;
        logic [11:0] bl2;
        logic        v1;
        logic        v2;
    } stb_t;

    state_t                    state, state_nxt;
    logic [11:0]               cnt, phase_len;
    logic                      last;
    stb_t                      stb_in;
    stb_t [ROM_LAT:1]          stb_pipe;
    logic signed [31:0]        best, best_nxt;
    logic [3:0]                idx, idx_nxt;

    always_comb begin
        phase_len = 12'd1;
        case (state)
            S_BIAS1:            phase_len = 12'(N_HID);
            S_PIX:              phase_len = 12'(N_PIX);
            S_DRAIN1, S_DRAIN2: phase_len = 12'(ROM_LAT);
            S_BIAS2:            phase_len = 12'(N_OUT);
            S_HID:              phase_len = 12'(N_HID);
            S_ARG:              phase_len = 12'(N_OUT);
            default:            phase_len = 12'd1;
        endcase
    end

    assign last = (cnt == phase_len - 12'd1);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state_nxt = S_CLR;
                S_CLR:    if (last)  state_nxt = S_BIAS1;
                S_BIAS1:  if (last)  state_nxt = S_PIX;
                S_PIX:    if (last)  state_nxt = S_DRAIN1;
                S_DRAIN1: if (last)  state_nxt = S_BIAS2;
                S_BIAS2:  if (last)  state_nxt = S_HID;
                S_HID:    if (last)  state_nxt = S_DRAIN2;
                S_DRAIN2: if (last)  state_nxt = S_SETTLE;
                S_SETTLE: if (last)  state_nxt = S_ARG;
                S_ARG:    if (last)  state_nxt = S_DONE;
                S_DONE:   if (last)  state_nxt = S_IDLE;
                default:             state_nxt = S_IDLE;
            endcase
        end
    end

    // output logic: addresses decode from the phase counter, strobes come out of the delay line
    always_comb begin
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        neuron_clr   = (state == S_CLR);
        pixel_addr   = (state == S_PIX) ? cnt : 12'd0;
        bias_addr    = (state == S_BIAS1 || state == S_BIAS2) ? cnt[3:0] : 4'd0;
        hid_addr     = (state == S_HID) ? cnt[3:0] : 4'd0;
        score_sel    = (state == S_ARG) ? cnt[3:0] : 4'd0;
        stb_in.bl1   = (state == S_BIAS1) ? (12'd1 << (cnt[3:0] + 4'd1)) : 12'd0;
        stb_in.bl2   = (state == S_BIAS2) ? (12'd1 << (cnt[3:0] + 4'd1)) : 12'd0;
        stb_in.v1    = (state == S_PIX);
        stb_in.v2    = (state == S_HID);
        bias_load_l1 = stb_pipe[ROM_LAT].bl1;
        bias_load_l2 = stb_pipe[ROM_LAT].bl2;
        valid_l1     = stb_pipe[ROM_LAT].v1;
        valid_l2     = stb_pipe[ROM_LAT].v2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                cnt <= 12'd0;
        else if (state_nxt != state || state == S_IDLE) cnt <= 12'd0;
        else                                       cnt <= cnt + 12'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || abort) begin
            stb_pipe <= '0;
        end else begin
            stb_pipe[1] <= stb_in;
            for (int i = 2; i <= ROM_LAT; i++) stb_pipe[i] <= stb_pipe[i-1];
        end
    end

    // first score seeds the running max; strict compare keeps the lowest index on ties
    always_comb begin
        best_nxt = best;
        idx_nxt  = idx;
        if (state == S_ARG && (cnt == 12'd0 || $signed(score) > best)) begin
            best_nxt = $signed(score);
            idx_nxt  = cnt[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best         <= '0;
            idx          <= 4'd0;
            digit        <= 4'd0;
            digit_onehot <= 10'd0;
        end else begin
            best <= best_nxt;
            idx  <= idx_nxt;
            if (state == S_ARG && last && !abort) begin
                digit        <= idx_nxt;
                digit_onehot <= 10'd1 << idx_nxt;
            end
        end
    end

endmodule
